// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
//   fwd_entry_t : one tracked in-flight instruction {valid, rd, is_load}
//   FWD_SEL_RF  : bypass select value that picks the register file
//   sel_w()     : width of a bypass select for a given tracking depth
package fwd_pkg;
  localparam int FWD_AW     = 5;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [FWD_AW-1:0] rd;
    logic              is_load;
  } fwd_entry_t;

  function automatic int sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fwd_match.sv
// Youngest-match priority encoder for one source operand.
//   chk_i         : operand is live (valid instr, used, src != x0)
//   src_i         : source register address
//   ent_i         : tracked entries, index 0 = youngest (EX)
//   sel_o         : FWD_SEL_RF on no match, else winning index + 1
//   is_load_hit_o : winning entry is a load
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = FWD_AW,
  parameter int SW    = sel_w(DEPTH)
) (
  input  logic                   chk_i,
  input  logic [AW-1:0]          src_i,
  input  fwd_entry_t [DEPTH-1:0] ent_i,
  output logic [SW-1:0]          sel_o,
  output logic                   is_load_hit_o
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel_o         = SW'(FWD_SEL_RF);
    is_load_hit_o = 1'b0;
    if (chk_i) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (ent_i[k].valid && (ent_i[k].rd != '0) && (ent_i[k].rd == src_i)) begin
          sel_o         = SW'(k + 1);
          is_load_hit_o = ent_i[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the in-order pipeline.
// Owns a DEPTH-entry shift pipeline of in-flight destinations that mirrors
// EX(0), MEM(1), WB(2)...; produces per-operand bypass selects and a
// load-use stall for ID, plus a saturating stall-cycle counter.
//   clk, rst_n           : clock, synchronous active-low reset
//   id_valid/id_src/...  : decode-stage instruction fields
//   pipe_hold            : global freeze, nothing advances
//   flush                : kill the ID instruction
//   fwd_sel              : bypass select per operand (0 = regfile, k+1 = entry k)
//   ld_stall             : hold front end, bubble into EX
//   stall_cnt            : cycles with ld_stall asserted
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter  int NSRC       = 2,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_STAGE = 1,
  parameter  int AW         = FWD_AW,
  parameter  int CNTW       = 32,
  localparam int SW         = sel_w(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic                 pipe_hold,
  input  logic                 flush,
  output logic [NSRC*SW-1:0]   fwd_sel,
  output logic                 ld_stall,
  output logic [CNTW-1:0]      stall_cnt
);

  fwd_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [NSRC-1:0]        hz;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      logic [AW-1:0] src;
      logic          chk;
      logic [SW-1:0] sel;
      logic          ld_hit;

      assign src = id_src[g*AW +: AW];
      assign chk = id_valid & id_src_used[g] & (src != '0);

      fwd_match #(.DEPTH(DEPTH), .AW(AW), .SW(SW)) u_match (
        .chk_i         (chk),
        .src_i         (src),
        .ent_i         (ent_q),
        .sel_o         (sel),
        .is_load_hit_o (ld_hit)
      );

      assign fwd_sel[g*SW +: SW] = sel;
      // sel = k+1, so k < LOAD_STAGE  <=>  sel <= LOAD_STAGE
      assign hz[g] = ld_hit & (sel != '0) & (sel <= SW'(LOAD_STAGE));
    end
  endgenerate

  assign ld_stall  = (|hz) & ~flush & ~pipe_hold;
  assign stall_cnt = cnt_q;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    if (!pipe_hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) ent_d[k] = ent_q[k-1];
      ent_d[0] = '0;
      if (ld_stall) begin
        if (~&cnt_q) cnt_d = cnt_q + CNTW'(1);
      end else if (!flush) begin
        ent_d[0].valid   = id_valid & id_wen;
        ent_d[0].rd      = id_rd;
        ent_d[0].is_load = id_is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

endmodule
